// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for the RV32M multiplier and divider. It launches one operation at a time,
// stalls the pipeline until the unit answers, resolves divide special cases locally, and drains killed operations.
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic        pipe_advance,
    input  logic        mul_en,
    input  logic [2:0]  mul_funct3,
    input  logic        div_en,
    input  logic        div_signed_en,
    input  logic        div_rem,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_a_signed,
    output logic        mul_b_signed,
    input  logic        mul_done,
    input  logic [63:0] mul_product,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_signed,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem_val,
    output logic        stall,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        DONE,
        DRAIN
    } state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_is_mul;
    logic          op_mul_hi;
    logic          op_rem;

    logic          req;
    logic          div_by_zero;
    logic          div_ovf;
    logic          unit_done;
    logic [31:0]   unit_result;

    assign req         = ex_valid & (mul_en | div_en) & ~flush;
    assign div_by_zero = (rs2_val == 32'h0);
    assign div_ovf     = div_signed_en && (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);

    // The outstanding op decides which unit's done pulse is meaningful, in both WAIT and DRAIN.
    assign unit_done   = op_is_mul ? mul_done : div_done;
    assign unit_result = op_is_mul ? (op_mul_hi ? mul_product[63:32] : mul_product[31:0])
                                   : (op_rem ? div_rem_val : div_quot);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves stall unassigned (no latch).
        stall = 1'b0;
        case (state)
            IDLE, DRAIN:        stall = req;
            MUL_WAIT, DIV_WAIT: stall = 1'b1;
            default:            stall = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            op_is_mul    <= 1'b0;
            op_mul_hi    <= 1'b0;
            op_rem       <= 1'b0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            mul_a_signed <= 1'b0;
            mul_b_signed <= 1'b0;
            div_start    <= 1'b0;
            div_a        <= '0;
            div_b        <= '0;
            div_signed   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_is_mul <= mul_en;
                        if (mul_en) begin
                            mul_a        <= rs1_val;
                            mul_b        <= rs2_val;
                            mul_a_signed <= ~(mul_funct3[1] & mul_funct3[0]);
                            mul_b_signed <= ~mul_funct3[1];
                            op_mul_hi    <= (mul_funct3 != 3'b000);
                            mul_start    <= 1'b1;
                            state        <= MUL_WAIT;
                        end else begin
                            op_rem <= div_rem;
                            if (div_by_zero) begin
                                result       <= div_rem ? rs1_val : 32'hFFFF_FFFF;
                                result_valid <= 1'b1;
                                state        <= DONE;
                            end else if (div_ovf) begin
                                result       <= div_rem ? 32'h0 : 32'h8000_0000;
                                result_valid <= 1'b1;
                                state        <= DONE;
                            end else begin
                                div_a      <= rs1_val;
                                div_b      <= rs2_val;
                                div_signed <= div_signed_en;
                                div_start  <= 1'b1;
                                state      <= DIV_WAIT;
                            end
                        end
                    end
                end
                MUL_WAIT, DIV_WAIT: begin
                    // A kill wins over a same-cycle answer; that answer then retires the drain at once.
                    if (flush) begin
                        cnt   <= '0;
                        state <= unit_done ? IDLE : DRAIN;
                    end else if (unit_done) begin
                        cnt          <= '0;
                        result       <= unit_result;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt          <= '0;
                        timeout_err  <= 1'b1;
                        result       <= '0;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt <= '0;
                    if (pipe_advance || flush) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (unit_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: each operation's timeline is derived from its latency,
// flush point and advance delay, and results come from plain RV32M arithmetic.
module tb_muldiv_sequencer;

    localparam int T     = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, flush, pipe_advance;
    logic        mul_en, div_en, div_signed_en, div_rem;
    logic [2:0]  mul_funct3;
    logic [31:0] rs1_val, rs2_val;
    logic        mul_start, mul_a_signed, mul_b_signed, mul_done;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_product;
    logic        div_start, div_signed, div_done;
    logic [31:0] div_a, div_b, div_quot, div_rem_val;
    logic        stall, result_valid, timeout_err;
    logic [31:0] result;

    muldiv_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush), .pipe_advance(pipe_advance),
        .mul_en(mul_en), .mul_funct3(mul_funct3), .div_en(div_en), .div_signed_en(div_signed_en),
        .div_rem(div_rem), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_a_signed(mul_a_signed),
        .mul_b_signed(mul_b_signed), .mul_done(mul_done), .mul_product(mul_product),
        .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_signed(div_signed),
        .div_done(div_done), .div_quot(div_quot), .div_rem_val(div_rem_val),
        .stall(stall), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_mul;
        logic [2:0]  f3;
        bit          sgn;
        bit          rem;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;        // cycles from launch pulse to done (0 = same cycle)
        int          flush_at;   // WAIT cycle index that carries flush, -1 for none
        int          adv;        // DONE cycles before pipe_advance
        bit          done_flush; // leave DONE through flush instead of advance
    } op_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic bit mul_sa(input logic [2:0] f3);
        return f3 != 3'b011;
    endfunction

    function automatic bit mul_sb(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001);
    endfunction

    function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                              input bit sa, input bit sb);
        logic [63:0] xa, xb;
        xa = sa ? {{32{a[31]}}, a} : {32'h0, a};
        xb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int ia, ib;
        logic [31:0] q, r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            ia = a;
            ib = b;
            q  = 32'(ia / ib);
            r  = 32'(ia % ib);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    function automatic logic [31:0] model_result(input op_t o);
        logic [63:0] p;
        if (o.is_mul) begin
            p = mul_full(o.a, o.b, mul_sa(o.f3), mul_sb(o.f3));
            return (o.f3 == 3'b000) ? p[31:0] : p[63:32];
        end
        p = div_model(o.a, o.b, o.sgn);
        return o.rem ? p[31:0] : p[63:32];
    endfunction

    // ---------------- per-cycle expectations and compare process ----------------
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_mul_start, exp_div_start, exp_valid;
    logic        exp_err = 1'b0;
    logic [31:0] exp_result;
    int          stall_cnt, mstart_cnt, dstart_cnt;
    logic [31:0] last_result;

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 64'(stall), 64'(exp_stall));
            check("mul_start", 64'(mul_start), 64'(exp_mul_start));
            check("div_start", 64'(div_start), 64'(exp_div_start));
            check("result_valid", 64'(result_valid), 64'(exp_valid));
            check("timeout_err", 64'(timeout_err), 64'(exp_err));
            if (exp_valid) check("result", 64'(result), 64'(exp_result));
            if (stall) stall_cnt++;
            if (mul_start) mstart_cnt++;
            if (div_start) dstart_cnt++;
            if (result_valid) last_result = result;
        end
    end

    task automatic set_exp(input bit s, input bit ms, input bit ds, input bit v, input logic [31:0] r);
        exp_stall     = s;
        exp_mul_start = ms;
        exp_div_start = ds;
        exp_valid     = v;
        exp_result    = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        flush        = 1'b0;
        pipe_advance = 1'b0;
        mul_done     = 1'b0;
        div_done     = 1'b0;
        mul_product  = {$urandom(), $urandom()};
        div_quot     = $urandom();
        div_rem_val  = $urandom();
    endtask

    task automatic drive_bubble();
        ex_valid      = 1'b0;
        mul_en        = 1'b0;
        div_en        = 1'b0;
        mul_funct3    = 3'($urandom_range(0, 3));
        div_signed_en = 1'b0;
        div_rem       = 1'b0;
        rs1_val       = $urandom();
        rs2_val       = $urandom();
    endtask

    task automatic drive_op(input op_t o);
        ex_valid      = 1'b1;
        mul_en        = o.is_mul;
        div_en        = !o.is_mul;
        mul_funct3    = o.f3;
        div_signed_en = o.sgn;
        div_rem       = o.rem;
        rs1_val       = o.a;
        rs2_val       = o.b;
    endtask

    // Behaves as the arithmetic unit: answers from the operands the sequencer presented.
    task automatic pulse_done(input bit is_mul);
        if (is_mul) begin
            mul_done    = 1'b1;
            mul_product = mul_full(mul_a, mul_b, mul_a_signed, mul_b_signed);
        end else begin
            div_done = 1'b1;
            {div_quot, div_rem_val} = div_model(div_a, div_b, div_signed);
        end
    endtask

    task automatic spurious_done();
        if ($urandom_range(0, 3) == 0) mul_done = 1'b1;
        if ($urandom_range(0, 3) == 0) div_done = 1'b1;
    endtask

    // Drives one M instruction from its request cycle until the sequencer is back in IDLE.
    task automatic run_op(input op_t o, input op_t nx, input bit nx_in_drain, output bit nx_held);
        logic [31:0] res;
        bit special, flushed, wait_to, drain_to;
        int wait_n, drain_n, done_n;
        special  = !o.is_mul && (o.b == 32'h0 || (o.sgn && o.a == 32'h8000_0000 && o.b == 32'hFFFF_FFFF));
        flushed  = !special && (o.flush_at >= 0);
        wait_n   = 0;
        drain_n  = 0;
        done_n   = 0;
        wait_to  = 1'b0;
        drain_to = 1'b0;
        res      = model_result(o);
        if (special) begin
            done_n = o.adv + 1;
        end else if (flushed) begin
            wait_n = o.flush_at + 1;
            if (o.lat > o.flush_at) begin
                if (o.lat - o.flush_at <= T) drain_n = o.lat - o.flush_at;
                else begin
                    drain_n  = T;
                    drain_to = 1'b1;
                end
            end
        end else begin
            done_n = o.adv + 1;
            if (o.lat < T) wait_n = o.lat + 1;
            else begin
                wait_n  = T;
                wait_to = 1'b1;
                res     = '0;
            end
        end
        nx_held = (drain_n > 0) && nx_in_drain;

        clear_pulses();
        drive_op(o);
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step();

        for (int i = 0; i < wait_n; i++) begin
            clear_pulses();
            drive_op(o);
            if (flushed && i == o.flush_at) flush = 1'b1;
            if (i == 0) begin
                if (o.is_mul) begin
                    check("mul_a", 64'(mul_a), 64'(o.a));
                    check("mul_b", 64'(mul_b), 64'(o.b));
                    check("mul_a_signed", 64'(mul_a_signed), 64'(mul_sa(o.f3)));
                    check("mul_b_signed", 64'(mul_b_signed), 64'(mul_sb(o.f3)));
                end else begin
                    check("div_a", 64'(div_a), 64'(o.a));
                    check("div_b", 64'(div_b), 64'(o.b));
                    check("div_signed", 64'(div_signed), 64'(o.sgn));
                end
            end
            if (i == o.lat) pulse_done(o.is_mul);
            set_exp(1'b1, (i == 0) && o.is_mul, (i == 0) && !o.is_mul, 1'b0, '0);
            step();
        end
        if (wait_to) exp_err = 1'b1;

        for (int j = 0; j < drain_n; j++) begin
            clear_pulses();
            if (nx_in_drain) drive_op(nx);
            else drive_bubble();
            if (wait_n + j == o.lat) pulse_done(o.is_mul);
            set_exp(nx_in_drain, 1'b0, 1'b0, 1'b0, '0);
            step();
        end
        if (drain_to) exp_err = 1'b1;

        for (int k = 0; k < done_n; k++) begin
            clear_pulses();
            drive_op(o);
            spurious_done();
            if (k == done_n - 1) begin
                if (o.done_flush) flush = 1'b1;
                else pipe_advance = 1'b1;
            end
            set_exp(1'b0, 1'b0, 1'b0, 1'b1, res);
            step();
        end
    endtask

    task automatic gap_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clear_pulses();
            drive_bubble();
            case ($urandom_range(0, 2))
                0: mul_en = 1'($urandom_range(0, 1));
                1: begin
                    ex_valid = 1'b1;
                    div_en   = 1'b1;
                    flush    = 1'b1;
                end
                default: ex_valid = 1'b1;
            endcase
            spurious_done();
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0);
            step();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    function automatic op_t gen_op(input bit allow_to);
        op_t o;
        int  r;
        o.is_mul     = 1'($urandom_range(0, 1));
        o.f3         = 3'($urandom_range(0, 3));
        o.sgn        = 1'($urandom_range(0, 1));
        o.rem        = 1'($urandom_range(0, 1));
        o.a          = pick_operand();
        o.b          = pick_operand();
        r            = $urandom_range(0, 9);
        if (r < 6)                 o.lat = $urandom_range(0, 3);
        else if (!allow_to)        o.lat = T - 1;
        else if (r < 8)            o.lat = $urandom_range(T - 1, T);
        else                       o.lat = NEVER;
        o.flush_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (o.lat < T - 1) ? o.lat : T - 1) : -1;
        o.adv        = $urandom_range(0, 2);
        o.done_flush = ($urandom_range(0, 5) == 0);
        return o;
    endfunction

    function automatic op_t mk(input bit is_mul, input logic [2:0] f3, input bit sgn, input bit rem,
                               input logic [31:0] a, input logic [31:0] b, input int lat,
                               input int flush_at, input int adv);
        op_t o;
        o.is_mul = is_mul;  o.f3 = f3;    o.sgn = sgn;           o.rem = rem;
        o.a = a;            o.b = b;      o.lat = lat;           o.flush_at = flush_at;
        o.adv = adv;        o.done_flush = 1'b0;
        return o;
    endfunction

    task automatic random_phase(input int n_ops, input bit allow_to);
        op_t cur, nxt;
        bit  held;
        cur = gen_op(allow_to);
        for (int i = 0; i < n_ops; i++) begin
            nxt = gen_op(allow_to);
            run_op(cur, nxt, 1'($urandom_range(0, 1)), held);
            if (!held) gap_cycles($urandom_range(0, 2));
            cur = nxt;
        end
    endtask

    op_t d_op, n_op;
    bit  held;

    initial begin
        rst = 1'b0;
        clear_pulses();
        drive_bubble();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mul_start", 64'(mul_start), 64'h0);
        check("rst_div_start", 64'(div_start), 64'h0);
        check("rst_result", 64'(result), 64'h0);
        check("rst_valid", 64'(result_valid), 64'h0);
        check("rst_err", 64'(timeout_err), 64'h0);
        check("rst_mul_a", 64'(mul_a), 64'h0);
        check("rst_div_b", 64'(div_b), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        rst = 1'b1;
        step();

        // The reference arithmetic itself, pinned to hand-computed values.
        check("pin_mul", 64'(model_result(mk(1, 3'b000, 0, 0, 32'd7, 32'hFFFF_FFFD, 0, -1, 0))), 64'hFFFF_FFEB);
        check("pin_mulhu", 64'(model_result(mk(1, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0))), 64'hFFFF_FFFE);
        check("pin_mulh", 64'(model_result(mk(1, 3'b001, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0))), 64'h0);
        check("pin_mulhsu", 64'(model_result(mk(1, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 0))), 64'hFFFF_FFFF);
        check("pin_div", 64'(model_result(mk(0, 3'b000, 1, 0, 32'hFFFF_FFF9, 32'd2, 0, -1, 0))), 64'hFFFF_FFFD);
        check("pin_rem", 64'(model_result(mk(0, 3'b000, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, -1, 0))), 64'hFFFF_FFFF);
        check("pin_divu", 64'(model_result(mk(0, 3'b000, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, -1, 0))), 64'h7FFF_FFFC);

        chk_en = 1'b1;
        n_op   = mk(1, 3'b000, 0, 0, 32'd3, 32'd5, 0, -1, 0);

        // mul 7 * -3 with the unit answering on the third cycle after the request.
        stall_cnt = 0;  mstart_cnt = 0;
        run_op(mk(1, 3'b000, 0, 0, 32'd7, 32'hFFFF_FFFD, 2, -1, 1), n_op, 0, held);
        check("dir_mul_stall_cycles", 64'(stall_cnt), 64'd4);
        check("dir_mul_starts", 64'(mstart_cnt), 64'd1);
        check("dir_mul_result", 64'(last_result), 64'hFFFF_FFEB);

        run_op(mk(1, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1, 0), n_op, 0, held);
        check("dir_mulhu_result", 64'(last_result), 64'hFFFF_FFFE);

        // Divide by zero and signed overflow never reach the divider.
        stall_cnt = 0;  dstart_cnt = 0;
        run_op(mk(0, 3'b000, 1, 0, 32'd100, 32'd0, 0, -1, 0), n_op, 0, held);
        check("dir_div0_stall_cycles", 64'(stall_cnt), 64'd1);
        check("dir_div0_result", 64'(last_result), 64'hFFFF_FFFF);
        run_op(mk(0, 3'b000, 0, 1, 32'd100, 32'd0, 0, -1, 1), n_op, 0, held);
        check("dir_remu0_result", 64'(last_result), 64'd100);
        run_op(mk(0, 3'b000, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0), n_op, 0, held);
        check("dir_ovf_div_result", 64'(last_result), 64'h8000_0000);
        run_op(mk(0, 3'b000, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 0), n_op, 0, held);
        check("dir_ovf_rem_result", 64'(last_result), 64'h0);
        check("dir_special_no_div_start", 64'(dstart_cnt), 64'd0);

        // Flush on the second DIV_WAIT cycle with a mul waiting behind it.
        mstart_cnt = 0;
        run_op(mk(0, 3'b000, 0, 0, 32'd1000, 32'd7, 4, 1, 0), n_op, 1, held);
        check("dir_drain_no_early_mul", 64'(mstart_cnt), 64'd0);
        run_op(n_op, n_op, 0, held);
        check("dir_drain_mul_result", 64'(last_result), 64'd15);

        random_phase(150, 1'b0);
        check("no_timeout_yet", 64'(timeout_err), 64'h0);

        // The multiplier never answers.
        run_op(mk(1, 3'b000, 0, 0, 32'd9, 32'd9, NEVER, -1, 1), n_op, 0, held);
        check("dir_timeout_err", 64'(timeout_err), 64'h1);
        check("dir_timeout_result", 64'(last_result), 64'h0);

        // Reset in the middle of DIV_WAIT.
        chk_en = 1'b0;
        d_op   = mk(0, 3'b000, 0, 0, 32'd100, 32'd7, NEVER, -1, 0);
        clear_pulses();
        drive_op(d_op);
        step();
        step();
        #2;
        drive_bubble();
        rst = 1'b0;
        #1;
        check("mid_rst_mul_start", 64'(mul_start), 64'h0);
        check("mid_rst_div_start", 64'(div_start), 64'h0);
        check("mid_rst_div_a", 64'(div_a), 64'h0);
        check("mid_rst_div_b", 64'(div_b), 64'h0);
        check("mid_rst_div_signed", 64'(div_signed), 64'h0);
        check("mid_rst_mul_a", 64'(mul_a), 64'h0);
        check("mid_rst_mul_b", 64'(mul_b), 64'h0);
        check("mid_rst_signs", 64'({mul_a_signed, mul_b_signed}), 64'h0);
        check("mid_rst_stall", 64'(stall), 64'h0);
        check("mid_rst_result", 64'(result), 64'h0);
        check("mid_rst_valid", 64'(result_valid), 64'h0);
        check("mid_rst_err", 64'(timeout_err), 64'h0);
        step();
        #2;
        rst     = 1'b1;
        exp_err = 1'b0;
        step();
        chk_en = 1'b1;
        gap_cycles(1);
        run_op(mk(0, 3'b000, 1, 1, 32'hFFFF_FFF9, 32'd2, 0, -1, 0), n_op, 0, held);
        check("post_rst_rem_result", 64'(last_result), 64'hFFFF_FFFF);

        random_phase(150, 1'b1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
